regfile_mp: RTL

- Parametrised multi-port register file for the pipelined datapath; successor to the single-cycle register file.
- Clocked writes from two write ports: the main writeback port and a late-load/multicycle-unit port.
- N combinational read ports, with optional same-cycle write-to-read bypass and register 0 hardwired to zero.
- Per-register pending scoreboard: the issue stage marks a destination pending, a write to it clears the mark, and read ports report busy so the hazard unit can stall.

---
 rtl/regfile_mp.sv | 89 ++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file for the pipelined datapath: two write ports, NRD combinational
// read ports with optional write-to-read bypass, and a per-register pending scoreboard.
module regfile_mp #(
  parameter int DW     = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH),
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_waw,
  output logic [AW:0]       pend_cnt
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [AW:0]      pend_cnt_q, pend_cnt_d;

  // Issue beats a simultaneous write: the newly issued producer is the one still outstanding.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < DEPTH; r++) begin
      if (iss_en && (iss_addr == AW'(r))) begin
        pend_d[r] = 1'b1;
      end else if ((we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)))) begin
        pend_d[r] = 1'b0;
      end
    end
    pend_d[0] = 1'b0;
    pend_cnt_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pend_d[r]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      // Port 1 is written last so it wins a same-address collision.
      if (we0 && (wa0 != '0)) mem_q[wa0] <= wd0;
      if (we1 && (wa1 != '0)) mem_q[wa1] <= wd1;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit0, hit1;
    logic [DW-1:0] data;

    always_comb begin
      addr = rd_addr[k*AW +: AW];
      hit0 = (BYPASS != 0) && we0 && (wa0 == addr);
      hit1 = (BYPASS != 0) && we1 && (wa1 == addr);
      data = mem_q[addr];
      if (hit1) begin
        data = wd1;
      end else if (hit0) begin
        data = wd0;
      end
      if ((addr == '0) || rst) data = '0;
    end

    assign rd_data[k*DW +: DW] = data;
    assign rd_busy[k]          = !rst && pend_q[addr] && !(hit0 || hit1);
  end

  assign iss_waw  = !rst && iss_en && (iss_addr != '0) && pend_q[iss_addr];
  assign pend_cnt = pend_cnt_q;

endmodule
